// File: rtl/jt12_eg_lin_pkg.sv
// Shared widths and the exponential table generator for the log-to-linear path.
package jt12_eg_lin_pkg;
  localparam int ATT_W    = 10;
  localparam int LOGSIN_W = 12;
  localparam int SUM_W    = 13;
  localparam int EXP_W    = 11;
  localparam int LIN_W    = 14;
  localparam int MAG_W    = SUM_W;
  localparam int SHIFT_W  = SUM_W - 8;

  // round(1024 * 2^(-m/256)); only ever evaluated at elaboration time
  function automatic logic [EXP_W-1:0] exp_tab(input int m);
    real r;
    r = 1024.0 * (2.0 ** (-real'(m) / 256.0));
    return EXP_W'($rtoi(r + 0.5));
  endfunction
endpackage

// File: rtl/jt12_exprom.sv
// 256x11 registered exponential ROM; one cen-qualified cycle from address to data.
module jt12_exprom
  import jt12_eg_lin_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_cen,
  input  logic [7:0]       i_addr,
  output logic [EXP_W-1:0] o_data
);
  logic [EXP_W-1:0] w_tab [256];

  for (genvar g = 0; g < 256; g++) begin : g_tab
    assign w_tab[g] = exp_tab(g);
  end

  always_ff @(posedge i_clk) begin
    if (i_cen) o_data <= w_tab[i_addr];
  end
endmodule

// File: rtl/jt12_eg_lin.sv
// Log-to-linear operator back end: 3 cen-qualified stages, no back-pressure.
// Optional peak-hold register enabled with JT12_EG_LIN_PEAK_EN.
module jt12_eg_lin
  import jt12_eg_lin_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cen,
  input  logic                in_valid,
  input  logic [ATT_W-1:0]    att,
  input  logic [LOGSIN_W-1:0] logsin,
  input  logic                sign,
  input  logic                peak_clr,
  output logic                out_valid,
  output logic [LIN_W-1:0]    lin,
  output logic [MAG_W-1:0]    peak
);
  logic [SUM_W:0]     w_sum_full;
  logic [SUM_W-1:0]   w_sum;
  logic [SUM_W-1:0]   r_s1_sum;
  logic               r_s1_sign;
  logic               r_s1_vld;
  logic [SHIFT_W-1:0] r_s2_exp;
  logic               r_s2_sign;
  logic               r_s2_vld;
  logic [EXP_W-1:0]   w_rom;
  logic [MAG_W-1:0]   w_mag;
  logic [LIN_W-1:0]   w_lin;
  logic               r_out_valid;
  logic [LIN_W-1:0]   r_lin;

  assign w_sum_full = {2'b00, logsin} + {2'b00, att, 2'b00};
  assign w_sum      = w_sum_full[SUM_W] ? {SUM_W{1'b1}} : w_sum_full[SUM_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_sum  <= '0;
      r_s1_sign <= 1'b0;
      r_s1_vld  <= 1'b0;
    end else if (cen) begin
      r_s1_sum  <= w_sum;
      r_s1_sign <= sign;
      r_s1_vld  <= in_valid;
    end
  end

  jt12_exprom u_exprom (
    .i_clk  (clk),
    .i_cen  (cen),
    .i_addr (r_s1_sum[7:0]),
    .o_data (w_rom)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_exp  <= '0;
      r_s2_sign <= 1'b0;
      r_s2_vld  <= 1'b0;
    end else if (cen) begin
      r_s2_exp  <= r_s1_sum[SUM_W-1:8];
      r_s2_sign <= r_s1_sign;
      r_s2_vld  <= r_s1_vld;
    end
  end

  // Shifts of 13 or more drain every bit, so large exponents fall to 0 naturally
  assign w_mag = {w_rom, 2'b00} >> r_s2_exp;
  assign w_lin = r_s2_sign ? (-{1'b0, w_mag}) : {1'b0, w_mag};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_lin       <= '0;
    end else if (cen) begin
      r_out_valid <= r_s2_vld;
      if (r_s2_vld) r_lin <= w_lin;
    end
  end

  assign out_valid = r_out_valid;
  assign lin       = r_lin;

`ifdef JT12_EG_LIN_PEAK_EN
  logic [MAG_W-1:0] r_peak;

  // A clear coinciding with a valid sample loads that sample's magnitude
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_peak <= '0;
    end else if (cen) begin
      if (r_s2_vld) begin
        if (peak_clr || (w_mag > r_peak)) r_peak <= w_mag;
      end else if (peak_clr) begin
        r_peak <= '0;
      end
    end
  end

  assign peak = r_peak;
`else
  logic w_unused_peak_clr;
  assign w_unused_peak_clr = peak_clr;
  assign peak = '0;
`endif
endmodule
